// File: rtl/l2_mem_responder.sv
// Line-granular backing store for the L2 physical-memory port: one transaction
// at a time, fixed access latency, optional periodic refresh that defers acceptance.
module l2_mem_responder #(
   parameter int ADDR_WIDTH     = 32,
   parameter int LINE_WIDTH     = 256,
   parameter int DEPTH_LOG2     = 6,
   parameter int LATENCY        = 4,
   parameter int REFRESH_PERIOD = 0,
   parameter int REFRESH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_cyc,
   input  logic                  mem_stb,
   input  logic                  mem_we,
   input  logic [ADDR_WIDTH-1:0] mem_adr,
   input  logic [LINE_WIDTH-1:0] mem_wdata,
   output logic [LINE_WIDTH-1:0] mem_rdata,
   output logic                  mem_ack,
   output logic                  mem_rty,
   output logic [1:0]            dbg_state_o
);

   localparam int ADDR_LSB  = $clog2(LINE_WIDTH / 8);
   localparam int IDX_HI    = ADDR_LSB + DEPTH_LOG2 - 1;
   localparam int NUM_LINES = 1 << DEPTH_LOG2;
   localparam int RCW       = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [7:0]     LAT_M1   = 8'(LATENCY - 1);
   localparam logic [RCW-1:0] REF_LAST = RCW'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
   localparam logic [RCW-1:0] REF_WIN  = RCW'(REFRESH_CYCLES);
   localparam bit             REF_EN   = (REFRESH_PERIOD != 0);

   // Handshake: the initiator holds mem_cyc & mem_stb until mem_ack. A request
   // seen in IDLE during a refresh window gets mem_rty and stays pending; after
   // the one-cycle mem_ack the initiator must drop mem_stb for a cycle.

   logic [1:0]            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [RCW-1:0]        ref_cnt_q, ref_cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic                  we_q, we_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic                  ack_q, ack_d;
   logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

   logic                  req;
   logic                  refresh_active;
   logic                  fire;
   logic                  wr_en;
   logic                  unused_adr_bits;

   logic [LINE_WIDTH-1:0] mem_q [NUM_LINES];

   assign req            = mem_cyc & mem_stb;
   assign refresh_active = REF_EN && (ref_cnt_q < REF_WIN);
   assign unused_adr_bits = ^{mem_adr[ADDR_WIDTH-1:IDX_HI+1], mem_adr[ADDR_LSB-1:0]};

   always_comb begin
      if (!REF_EN || (ref_cnt_q == REF_LAST)) begin
         ref_cnt_d = '0;
      end else begin
         ref_cnt_d = ref_cnt_q + RCW'(1);
      end
   end

   // fire marks the edge that performs the array access and raises mem_ack;
   // the _d copies of the transaction fields are the values used at that edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      ack_d   = 1'b0;
      fire    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req && !refresh_active) begin
               idx_d   = mem_adr[IDX_HI:ADDR_LSB];
               we_d    = mem_we;
               wdata_d = mem_wdata;
               cnt_d   = LAT_M1;
               if (LATENCY == 1) begin
                  fire    = 1'b1;
                  ack_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            if (!mem_cyc) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  fire    = 1'b1;
                  ack_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (!mem_stb) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign wr_en = fire & we_d & rst_n;

   always_comb begin
      rdata_d = rdata_q;
      if (fire && !we_d) begin
         rdata_d = mem_q[idx_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ref_cnt_q <= '0;
         idx_q     <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ref_cnt_q <= ref_cnt_d;
         idx_q     <= idx_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
      end
   end

   // Storage is deliberately not reset; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[idx_d] <= wdata_d;
      end
   end

   assign mem_ack     = ack_q;
   assign mem_rdata   = rdata_q;
   assign mem_rty     = rst_n & (state_q == S_IDLE) & req & refresh_active;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: three configurations driven independently and
// checked every cycle against a transaction-level model, plus directed cases.
module tb_l2_mem_responder;

   localparam int LAT_T [3] = '{4, 4, 1};
   localparam int PER_T [3] = '{0, 16, 5};
   localparam int RCY_T [3] = '{2, 2, 3};
   localparam int ST_IDLE = 0;
   localparam int ST_BUSY = 1;
   localparam int ST_DONE = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic         cyc [3];
   logic         stb [3];
   logic         we [3];
   logic [31:0]  adr [3];
   logic [255:0] wdata [3];
   logic [255:0] rdata [3];
   logic         ack [3];
   logic         rty [3];
   logic [1:0]   dbg [3];

   int checks   = 0;
   int failures = 0;

   // Model state: spec-level phase, edge count since reset, due edge of access.
   int           e_n [3];
   int           m_st [3];
   int           m_due [3];
   bit           m_we [3];
   int           m_idx [3];
   logic [255:0] m_wd [3];
   bit           m_ack [3];
   logic [255:0] m_rd [3];
   bit           m_rdk [3];
   logic [255:0] m_mem [3][64];
   bit           m_val [3][64];

   always #5 clk = ~clk;

   l2_mem_responder #(.LATENCY(4), .REFRESH_PERIOD(0), .REFRESH_CYCLES(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .mem_cyc(cyc[0]), .mem_stb(stb[0]), .mem_we(we[0]),
      .mem_adr(adr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ack(ack[0]),
      .mem_rty(rty[0]), .dbg_state_o(dbg[0]));

   l2_mem_responder #(.LATENCY(4), .REFRESH_PERIOD(16), .REFRESH_CYCLES(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .mem_cyc(cyc[1]), .mem_stb(stb[1]), .mem_we(we[1]),
      .mem_adr(adr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ack(ack[1]),
      .mem_rty(rty[1]), .dbg_state_o(dbg[1]));

   l2_mem_responder #(.LATENCY(1), .REFRESH_PERIOD(5), .REFRESH_CYCLES(3)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .mem_cyc(cyc[2]), .mem_stb(stb[2]), .mem_we(we[2]),
      .mem_adr(adr[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_ack(ack[2]),
      .mem_rty(rty[2]), .dbg_state_o(dbg[2]));

   function automatic bit ref_act(input int i);
      if (PER_T[i] == 0) return 1'b0;
      return (e_n[i] % PER_T[i]) < RCY_T[i];
   endfunction

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Reference model: updates on every clock edge and immediately on reset.
   initial begin
      bit fire;
      for (int i = 0; i < 3; i++) begin
         e_n[i] = 0; m_st[i] = ST_IDLE; m_ack[i] = 1'b0; m_rd[i] = '0; m_rdk[i] = 1'b1;
         for (int l = 0; l < 64; l++) m_val[i][l] = 1'b0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
               e_n[i] = 0; m_st[i] = ST_IDLE; m_ack[i] = 1'b0; m_rd[i] = '0; m_rdk[i] = 1'b1;
            end else begin
               fire = 1'b0;
               m_ack[i] = 1'b0;
               if (m_st[i] == ST_IDLE) begin
                  if (cyc[i] && stb[i] && !ref_act(i)) begin
                     m_we[i]  = we[i];
                     m_idx[i] = int'(adr[i][10:5]);
                     m_wd[i]  = wdata[i];
                     m_due[i] = e_n[i] + LAT_T[i] - 1;
                     m_st[i]  = ST_BUSY;
                  end
               end else if (m_st[i] == ST_BUSY) begin
                  if (!cyc[i]) m_st[i] = ST_IDLE;
               end else if (!stb[i]) begin
                  m_st[i] = ST_IDLE;
               end
               if (m_st[i] == ST_BUSY && m_due[i] == e_n[i]) begin
                  fire = 1'b1;
                  m_st[i] = ST_DONE;
               end
               if (fire) begin
                  m_ack[i] = 1'b1;
                  if (m_we[i]) begin
                     m_mem[i][m_idx[i]] = m_wd[i];
                     m_val[i][m_idx[i]] = 1'b1;
                     m_rdk[i] = 1'b0;
                  end else begin
                     m_rd[i]  = m_mem[i][m_idx[i]];
                     m_rdk[i] = m_val[i][m_idx[i]];
                  end
               end
               e_n[i]++;
            end
         end
      end
   end

   // Compare process on the falling edge.
   initial begin
      bit exp_rty;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
               chk($sformatf("rst_ack%0d", i), 256'(ack[i]), 256'(0));
               chk($sformatf("rst_rty%0d", i), 256'(rty[i]), 256'(0));
               chk($sformatf("rst_rdata%0d", i), rdata[i], 256'(0));
            end else begin
               exp_rty = (m_st[i] == ST_IDLE) && cyc[i] && stb[i] && ref_act(i);
               chk($sformatf("ack%0d", i), 256'(ack[i]), 256'(m_ack[i]));
               chk($sformatf("rty%0d", i), 256'(rty[i]), 256'(exp_rty));
               if (m_rdk[i]) chk($sformatf("rdata%0d", i), rdata[i], m_rd[i]);
            end
         end
      end
   end

   // Driver: called at posedge+1; returns at posedge+1 with stb sampled low once.
   task automatic do_txn(input int i, input bit w, input logic [31:0] a, input logic [255:0] d,
                         input int hold, output int edges, output int rtys, output int extra,
                         output logic [255:0] rd);
      bit got, seen_rty, scr;
      edges = 0; rtys = 0; extra = 0; got = 1'b0; scr = 1'b0; rd = '0;
      cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; wdata[i] = d;
      while (!got && edges < 400) begin
         #1;
         seen_rty = rty[i];
         if (seen_rty) rtys++;
         @(posedge clk);
         edges++;
         #1;
         if (ack[i]) begin
            got = 1'b1;
            rd  = rdata[i];
         end else if (!seen_rty && !scr) begin
            scr = 1'b1;
            we[i] = 1'($urandom_range(0, 1)); adr[i] = $urandom; wdata[i] = rand_line();
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL ack_timeout%0d act=no_ack exp=ack_within_400", i);
      end
      repeat (hold) begin
         @(posedge clk); #1;
         if (ack[i]) extra++;
      end
      stb[i] = 1'b0; cyc[i] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_abort(input int i, input bit w, input logic [31:0] a, input logic [255:0] d,
                           input int n, output int acks);
      acks = 0;
      cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; wdata[i] = d;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (ack[i]) acks++;
      end
      cyc[i] = 1'b0; stb[i] = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ack[i]) acks++;
      end
   endtask

   task automatic rand_ops(input int i, input int n);
      int e, r, x;
      logic [255:0] rd;
      logic [31:0] a;
      for (int k = 0; k < n; k++) begin
         a = $urandom;
         a[10:5] = 6'($urandom_range(0, 7));
         if ($urandom_range(0, 4) == 0) begin
            do_abort(i, 1'($urandom_range(0, 1)), a, rand_line(), $urandom_range(1, 5), x);
         end else begin
            do_txn(i, 1'($urandom_range(0, 1)), a, rand_line(), $urandom_range(0, 2), e, r, x, rd);
            chk($sformatf("rand_extra_ack%0d", i), 256'(x), 256'(0));
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      int e, r, x, guard;
      logic [255:0] rd, pat_a5, pat_12, d1, d2, x1, x2;
      for (int i = 0; i < 3; i++) begin
         cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; wdata[i] = '0;
      end
      pat_a5 = {32{8'hA5}};
      pat_12 = {8{32'h12345678}};
      d1 = rand_line(); d2 = ~d1; x1 = rand_line(); x2 = ~x1;

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_ack%0d", i), 256'(ack[i]), 256'(0));
         chk($sformatf("reset_rdata%0d", i), rdata[i], 256'(0));
         chk($sformatf("reset_state%0d", i), 256'(dbg[i]), 256'(0));
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Read latency and data.
      do_txn(0, 1'b1, 32'h60, pat_a5, 0, e, r, x, rd);
      chk("wr_latency", 256'(e), 256'(4));
      do_txn(0, 1'b0, 32'h60, '0, 0, e, r, x, rd);
      chk("rd_latency", 256'(e), 256'(4));
      chk("rd_data_a5", rd, pat_a5);

      // Held strobe in DONE, then read-back with low address bits set.
      do_txn(0, 1'b1, 32'hA0, pat_12, 3, e, r, x, rd);
      chk("done_hold_extra_ack", 256'(x), 256'(0));
      do_txn(0, 1'b0, 32'hBF, '0, 0, e, r, x, rd);
      chk("b2b_rd_data", rd, pat_12);

      // Aborted read and aborted write.
      do_abort(0, 1'b0, 32'h60, '0, 2, x);
      chk("abort_rd_acks", 256'(x), 256'(0));
      do_txn(0, 1'b1, 32'hE0, x1, 0, e, r, x, rd);
      do_abort(0, 1'b1, 32'hE0, x2, 2, x);
      chk("abort_wr_acks", 256'(x), 256'(0));
      do_txn(0, 1'b0, 32'hE0, '0, 0, e, r, x, rd);
      chk("abort_wr_kept", rd, x1);

      // Aliasing above the index bits.
      do_txn(0, 1'b1, 32'h20, d1, 0, e, r, x, rd);
      do_txn(0, 1'b0, 32'h820, '0, 0, e, r, x, rd);
      chk("alias_rd_data", rd, d1);

      // Single-cycle latency.
      do_txn(2, 1'b1, 32'h140, d2, 0, e, r, x, rd);
      chk("lat1_wr_edges", 256'(e - r), 256'(1));
      do_txn(2, 1'b0, 32'h140, '0, 0, e, r, x, rd);
      chk("lat1_rd_edges", 256'(e - r), 256'(1));
      chk("lat1_rd_data", rd, d2);

      // Refresh: request raised when the refresh counter is 0.
      guard = 0;
      do begin
         @(posedge clk); #1;
         guard++;
      end while ((e_n[1] % 16) != 0 && guard < 40);
      do_txn(1, 1'b1, 32'h60, pat_a5, 0, e, r, x, rd);
      chk("refresh_rty_cycles", 256'(r), 256'(2));
      chk("refresh_ack_edges", 256'(e), 256'(6));
      do_txn(1, 1'b0, 32'h60, '0, 0, e, r, x, rd);
      chk("refresh_rd_data", rd, pat_a5);

      // Reset in the middle of a write.
      do_txn(0, 1'b1, 32'h120, d1, 0, e, r, x, rd);
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h120; wdata[0] = d2;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_ack", 256'(ack[0]), 256'(0));
      chk("midrst_state", 256'(dbg[0]), 256'(0));
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_txn(0, 1'b0, 32'h120, '0, 0, e, r, x, rd);
      chk("midrst_rd_data", rd, d1);

      fork
         rand_ops(0, 40);
         rand_ops(1, 40);
         rand_ops(2, 40);
      join

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
